// File: rtl/run_pkg.sv
// Shared types and default register-file geometry for the run launcher and its neighbours.
package run_pkg;

    localparam int unsigned RUN_NUM_REGS = 16;
    localparam int unsigned RUN_DATA_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        DUMP,
        FINISH
    } run_state_t;

endpackage

// File: rtl/run_launcher_if.sv
// Launcher <-> processor/consumer signal bundle: Go/Start/Ack control, register-file read port, dump stream.
interface run_launcher_if
    import run_pkg::*;
#(
    parameter int unsigned NUM_REGS = RUN_NUM_REGS,
    parameter int unsigned DATA_W   = RUN_DATA_W
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic              go;
    logic              start;
    logic              ack;
    logic [IDX_W-1:0]  rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [DATA_W-1:0] dump_data;
    logic [IDX_W-1:0]  dump_idx;
    logic              dump_valid;
    logic              dump_ready;
    logic              busy;
    logic              done;
    logic              timed_out;

    modport master (
        input  go, ack, rf_data, dump_ready,
        output start, rf_addr, dump_data, dump_idx, dump_valid, busy, done, timed_out
    );

    modport slave (
        output go, ack, rf_data, dump_ready,
        input  start, rf_addr, dump_data, dump_idx, dump_valid, busy, done, timed_out
    );

endinterface

// File: rtl/run_cycle_counter.sv
// Loadable up-counter with clear/enable and a terminal-value compare, used for the launch and timeout phases.
module run_cycle_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] term_val_i,
    output logic         term_c_o
);

    logic [W-1:0] count_q, count_d;

    // Clear has priority so the counter always starts from zero on state entry
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_c_o = (count_q == term_val_i);

endmodule

// File: rtl/run_launcher.sv
// Host-side run initiator: pulses Start, waits for Ack under a timeout, then streams the register file out.
module run_launcher
    import run_pkg::*;
#(
    parameter int unsigned NUM_REGS     = RUN_NUM_REGS,
    parameter int unsigned DATA_W       = RUN_DATA_W,
    parameter int unsigned START_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1024
) (
    input logic            clk,
    input logic            rst_n,
    run_launcher_if.master run_io
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned LW    = $clog2(START_CYCLES + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    run_state_t        state_q, state_d;
    logic              start_q, start_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              to_q, to_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              launch_term_c;
    logic              wait_term_c;
    logic              fire_c;
    logic [DATA_W-1:0] data_c;

    run_cycle_counter #(.W(LW)) u_launch_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q != LAUNCH),
        .en_i       (state_q == LAUNCH),
        .load_i     (1'b0),
        .load_val_i ('0),
        .term_val_i (LW'(START_CYCLES - 1)),
        .term_c_o   (launch_term_c)
    );

    run_cycle_counter #(.W(TW)) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q != WAIT_ACK),
        .en_i       (state_q == WAIT_ACK),
        .load_i     (1'b0),
        .load_val_i ('0),
        .term_val_i (TW'(TIMEOUT - 1)),
        .term_c_o   (wait_term_c)
    );

    // DumpValid is high for exactly the DUMP cycles, so state alone qualifies a transfer
    assign fire_c = (state_q == DUMP) && run_io.dump_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack in WAIT_ACK beats the timeout on the final cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (run_io.go) state_d = LAUNCH;
            LAUNCH:   if (launch_term_c) state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (run_io.ack) begin
                    state_d = DUMP;
                end else if (wait_term_c) begin
                    state_d = FINISH;
                end
            end
            DUMP:     if (fire_c && (idx_q == IDX_W'(NUM_REGS - 1))) state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Done trails FINISH by a cycle, landing on the first IDLE cycle
    always_comb begin
        start_d = (state_d == LAUNCH);
        valid_d = (state_d == DUMP);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == FINISH);
        to_d    = to_q;
        idx_d   = idx_q;
        if ((state_q == IDLE) && run_io.go) begin
            to_d = 1'b0;
        end
        if ((state_q == WAIT_ACK) && !run_io.ack && wait_term_c) begin
            to_d = 1'b1;
        end
        if (fire_c) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            start_q <= start_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
        end
    end

    assign data_c            = run_io.rf_data;
    assign run_io.dump_data  = data_c;
    assign run_io.start      = start_q;
    assign run_io.dump_valid = valid_q;
    assign run_io.busy       = busy_q;
    assign run_io.done       = done_q;
    assign run_io.timed_out  = to_q;
    assign run_io.rf_addr    = idx_q;
    assign run_io.dump_idx   = idx_q;

endmodule

// File: tb/tb_run_launcher.sv
// Directed bench: instance A (START_CYCLES=1, TIMEOUT=1024) and instance B (START_CYCLES=3, TIMEOUT=8).
module tb_run_launcher;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [1:0] go_v, ack_v, rdy_v;
    logic [7:0] rf [16];

    run_launcher_if if_a ();
    run_launcher_if if_b ();

    run_launcher #(.START_CYCLES(1), .TIMEOUT(1024)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_io (if_a.master)
    );

    run_launcher #(.START_CYCLES(3), .TIMEOUT(8)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_io (if_b.master)
    );

    always #5 clk = ~clk;

    assign if_a.go         = go_v[0];
    assign if_b.go         = go_v[1];
    assign if_a.ack        = ack_v[0];
    assign if_b.ack        = ack_v[1];
    assign if_a.dump_ready = rdy_v[0];
    assign if_b.dump_ready = rdy_v[1];
    assign if_a.rf_data    = rf[if_a.rf_addr];
    assign if_b.rf_data    = rf[if_b.rf_addr];

    logic [1:0] ob_start, ob_valid, ob_busy, ob_done, ob_to;
    logic [3:0] ob_idx  [2];
    logic [7:0] ob_data [2];

    assign ob_start   = {if_b.start, if_a.start};
    assign ob_valid   = {if_b.dump_valid, if_a.dump_valid};
    assign ob_busy    = {if_b.busy, if_a.busy};
    assign ob_done    = {if_b.done, if_a.done};
    assign ob_to      = {if_b.timed_out, if_a.timed_out};
    assign ob_idx[0]  = if_a.dump_idx;
    assign ob_idx[1]  = if_b.dump_idx;
    assign ob_data[0] = if_a.dump_data;
    assign ob_data[1] = if_b.dump_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int sel, input string nm);
        check({nm, " start"}, 32'(ob_start[sel]), 0);
        check({nm, " valid"}, 32'(ob_valid[sel]), 0);
        check({nm, " busy"},  32'(ob_busy[sel]),  0);
        check({nm, " done"},  32'(ob_done[sel]),  0);
        check({nm, " idx"},   32'(ob_idx[sel]),   0);
    endtask

    // One run: Go on tick 0, Ack high for cycles >= ack_from, ready pattern 1,0,0 when bp
    task automatic run(input int sel, input int ack_from, input bit bp, input int rst_idx,
                       input int exp_first, input bit exp_to, input string nm);
        int s_cyc, t_cyc;
        int beats, first, done_t, dones, dcyc, starts;
        bit rdy;
        s_cyc  = (sel == 1) ? 3 : 1;
        t_cyc  = (sel == 1) ? 8 : 1024;
        beats  = 0; first = -1; done_t = -1; dones = 0; dcyc = 0; starts = 0;
        ack_v[sel] = (ack_from <= 0);
        rdy_v[sel] = 1'b1;
        go_v[sel]  = 1'b1;
        for (int t = 1; t <= 300; t++) begin
            tick();
            go_v[sel]  = 1'b0;
            ack_v[sel] = (t >= ack_from);
            if (t == 1) begin
                check({nm, " busy@1"}, 32'(ob_busy[sel]), 1);
                check({nm, " to_clr"}, 32'(ob_to[sel]),   0);
            end
            if (ob_start[sel]) starts++;
            if (ob_done[sel]) begin
                dones++;
                if (done_t < 0) done_t = t;
            end
            if (ob_valid[sel]) begin
                if (first < 0) first = t;
                if (rst_idx >= 0 && 32'(ob_idx[sel]) == 32'(rst_idx)) begin
                    rst_n = 1'b0;
                    #1;
                    check_idle(sel, {nm, " rst"});
                    ack_v[sel] = 1'b0;
                    return;
                end
                rdy = bp ? (dcyc % 3 == 0) : 1'b1;
                dcyc++;
                rdy_v[sel] = rdy;
                check({nm, rdy ? " idx" : " hold idx"}, 32'(ob_idx[sel]), 32'(beats));
                check({nm, rdy ? " data" : " hold data"}, 32'(ob_data[sel]), 32'(8'(beats * 3)));
                if (rdy) beats++;
            end else begin
                rdy_v[sel] = 1'b1;
            end
            if (done_t > 0 && t >= done_t + 2) break;
        end
        ack_v[sel] = 1'b0;
        rdy_v[sel] = 1'b1;
        check({nm, " start_cycles"}, 32'(starts), 32'(s_cyc));
        check({nm, " first_valid"},  32'(first),  32'(exp_first));
        check({nm, " beats"},        32'(beats),  exp_to ? 0 : 16);
        check({nm, " dones"},        32'(dones),  1);
        check({nm, " done_t"},       32'(done_t),
              exp_to ? 32'(s_cyc + t_cyc + 2) : 32'(first + dcyc + 1));
        check({nm, " timed_out"},    32'(ob_to[sel]), 32'(exp_to));
        check({nm, " idle_after"},   32'(ob_busy[sel]), 0);
    endtask

    initial begin
        for (int j = 0; j < 16; j++) rf[j] = 8'(j * 3);
        go_v = '0; ack_v = '0; rdy_v = '1;
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");
        check("reset_a to", 32'(ob_to[0]), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic: Ack 20 cycles after Start falls (k=20) -> first valid at 1+20+2
        run(0, 22, 1'b0, -1, 23, 1'b0, "basic");
        repeat (2) tick();
        // Backpressure with k=3
        run(0, 5, 1'b1, -1, 6, 1'b0, "bp");
        repeat (2) tick();
        // Reset in the middle of the dump, held low across a clock edge
        run(0, 5, 1'b0, 5, 6, 1'b0, "middump");
        tick();
        check_idle(0, "rst_held");
        #2 rst_n = 1'b1;
        repeat (2) tick();
        run(0, 5, 1'b0, -1, 6, 1'b0, "fresh");
        repeat (2) tick();

        // Timeout: WAIT_ACK spans 8 cycles, done 3+8+2 ticks after Go
        run(1, 1000, 1'b0, -1, -1, 1'b1, "timeout");
        repeat (3) tick();
        check("to_sticky", 32'(ob_to[1]), 1);
        // Stale Ack through LAUNCH: k=0 -> first valid at 3+2
        run(1, 0, 1'b0, -1, 5, 1'b0, "stale");
        repeat (2) tick();
        // Ack rises on the last timeout cycle (k=7)
        run(1, 11, 1'b0, -1, 12, 1'b0, "race");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/run_launcher.md
Name: run_launcher

Overview:
Host-side initiator for the TopLevel Start/Ack handshake. On a Go request it pulses Start, waits for the processor's Ack (done flag) under a cycle timeout, then reads the register file out one entry at a time and streams each value on a valid/ready dump port. It replaces the bench-level "pulse Req, wait, print registers" sequence with synthesizable control. It sits beside TopLevel, with RfAddr driving a read port of the register file.

Parameters:
NUM_REGS, 16, register-file entries to dump (power of 2, at least 2)
DATA_W, 8, register width
START_CYCLES, 1, cycles Start is held high (at least 1)
TIMEOUT, 1024, maximum WAIT_ACK cycles before abort (at least 1)

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Go  input  1  run request; sampled in IDLE only
Start  output  1  to TopLevel Start
Ack  input  1  from TopLevel Ack (done)
RfAddr  output  $clog2(NUM_REGS)  register-file read address
RfData  input  DATA_W  combinational read data for RfAddr
DumpData  output  DATA_W  register value being offered
DumpIdx  output  $clog2(NUM_REGS)  index of DumpData
DumpValid  output  1  dump beat valid
DumpReady  input  1  consumer accepts beat
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse at end of run (normal or timeout)
TimedOut  output  1  sticky: last run aborted on timeout

Behaviour:
- Reset (Reset low, asynchronous): state IDLE; Start, DumpValid, Done, Busy, TimedOut = 0; RfAddr, DumpIdx = 0; all counters = 0.
- FSM states: IDLE, LAUNCH, WAIT_ACK, DUMP, FINISH.
- IDLE: Go=1 moves to LAUNCH next cycle and clears TimedOut. Go=0 holds IDLE.
- LAUNCH: Start=1 for exactly START_CYCLES cycles, then WAIT_ACK. Ack is ignored here, so a stale Ack from a prior run cannot complete a new run.
- WAIT_ACK: Start=0. The cycle counter starts at 0 on entry and increments each cycle.
  - Ack=1 moves to DUMP.
  - With Ack=0 on the cycle where the counter equals TIMEOUT-1: set TimedOut=1 and go to FINISH, skipping the dump.
  - Ack=1 on the final timeout cycle wins: go to DUMP, TimedOut stays 0.
- DUMP: RfAddr = DumpIdx; DumpData = RfData (pass-through); DumpValid=1.
  - A beat transfers on a cycle where DumpValid && DumpReady are both high; DumpIdx then increments.
  - While DumpReady=0, DumpIdx, DumpData and DumpValid are held stable. The processor is halted after Ack, so RfData is stable.
  - A transfer at DumpIdx = NUM_REGS-1 moves to FINISH; DumpIdx wraps to 0 and DumpValid drops the next cycle.
- FINISH: Done=1 for one cycle, then IDLE. Busy=0 from IDLE onward.
- Go outside IDLE is ignored (no queuing). Go held high through FINISH starts a new run one cycle after re-entering IDLE.
- Latency with DumpReady tied high, Ack arriving k cycles after entering WAIT_ACK:
  - first DumpValid = START_CYCLES + k + 2 cycles after Go is sampled;
  - Done = NUM_REGS + 1 cycles after first DumpValid.
- Widths:
  - index counter is $clog2(NUM_REGS) bits and wraps naturally;
  - timeout counter is $clog2(TIMEOUT+1) bits;
  - launch counter is $clog2(START_CYCLES+1) bits;
  - no counter saturates outside its own state.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. A partial dump is not resumed.

Decomposition:
- Shared package run_pkg:
  - typedef enum logic [2:0] run_state_t {IDLE, LAUNCH, WAIT_ACK, DUMP, FINISH};
  - localparam default NUM_REGS/DATA_W so TopLevel and benches agree on register-file geometry.
- One natural sub-module: run_cycle_counter.
  - Loadable up-counter with clear, enable and terminal-compare output.
  - Instantiated twice, for the LAUNCH width and the WAIT_ACK timeout.
  - The FSM and dump indexing stay in the top module.

Test Plan:
- Basic run: registers preloaded R[j] = j*3, Ack asserted 20 cycles after Start falls, DumpReady=1 -> 16 beats DumpIdx 0..15 with DumpData 0x00,0x03,...,0x2D; then one Done pulse; TimedOut=0.
- Backpressure: DumpReady toggled 1,0,0,1,... during dump -> DumpData/DumpIdx stable while Ready=0; exactly 16 transfers, none lost or duplicated.
- Timeout: TIMEOUT=8, Ack held 0 -> WAIT_ACK lasts exactly 8 cycles; TimedOut=1; Done pulses; no DumpValid. Next Go clears TimedOut.
- Stale Ack: Ack=1 throughout LAUNCH (START_CYCLES=3) -> Start high 3 cycles; DUMP entered only via WAIT_ACK; first DumpValid at cycle START_CYCLES+2 after Go is sampled (k=0).
- Race: Ack rises on the last timeout cycle -> dump proceeds; TimedOut=0.
- Reset mid-dump: Reset low at DumpIdx=5 -> asynchronous clear to IDLE; Start, DumpValid, Busy, Done = 0 while Reset is low. After release, Go launches a full fresh run beginning at DumpIdx=0.
